// File: rtl/mips_pkg.sv
// Shared MIPS fetch definitions: word width, the NOP encoding and the fetch FSM states.
// Pure declarations; no timing or flow control.
package mips_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_t;
endpackage

// File: rtl/imem_ram.sv
// Single-port instruction memory: synchronous write, registered read, no reset.
// Read data appears one edge after re; rdata holds whenever re is low.
module imem_ram
   import mips_pkg::*;
#(
   parameter int MEM_WORDS = 256,
   parameter int IDX_W     = 8
) (
   input  logic            clk,
   input  logic            we,
   input  logic [IDX_W-1:0] widx,
   input  logic [XLEN-1:0] wdata,
   input  logic            re,
   input  logic [IDX_W-1:0] ridx,
   output logic [XLEN-1:0] rdata
);
   logic [XLEN-1:0] mem [MEM_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[widx] <= wdata;
      end
      if (re) begin
         rdata <= mem[ridx];
      end
   end
endmodule

// File: rtl/instr_fetch.sv
// IF stage: checks the PC, reads the instruction memory and registers instr/pc+4 into IF/ID.
// One-cycle fetch latency; stall holds IF/ID, flush/load/fault insert bubbles.
module instr_fetch
   import mips_pkg::*;
#(
   parameter int MEM_WORDS = 256,
   parameter int IDX_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [XLEN-1:0]  pc,
   input  logic             stall,
   input  logic             flush,
   input  logic             load_en,
   input  logic [IDX_W-1:0] load_idx,
   input  logic [XLEN-1:0]  load_data,
   output logic [XLEN-1:0]  instr,
   output logic [XLEN-1:0]  pc_plus4,
   output logic             if_valid,
   output logic             fault,
   output logic [XLEN-1:0]  fetch_count
);
   fetch_state_t    state, state_nxt;
   logic            pc_bad;
   logic            fetch_go;
   logic            bubble;
   logic            mem_we;
   logic [XLEN-1:0] rdata;
   logic [XLEN-1:0] pc4_q;
   logic [XLEN-1:0] cnt_q;
   logic            vld_q;

   assign pc_bad = (pc[1:0] != 2'b00) || (pc[XLEN-1:IDX_W+2] != '0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      fetch_go  = 1'b0;
      bubble    = 1'b0;
      mem_we    = 1'b0;
      case (state)
         RUN: begin
            if (flush) begin
               bubble = 1'b1;
            end else if (load_en) begin
               bubble = 1'b1;
               mem_we = 1'b1;
            end else if (stall) begin
               bubble = 1'b0;
            end else if (pc_bad) begin
               bubble    = 1'b1;
               state_nxt = FAULT;
            end else begin
               fetch_go = 1'b1;
            end
         end
         FAULT: begin
            // Only a program load gets through while faulted.
            bubble = 1'b1;
            mem_we = load_en;
         end
         default: begin
            state_nxt = RUN;
            bubble    = 1'b1;
         end
      endcase
   end

   imem_ram #(
      .MEM_WORDS (MEM_WORDS),
      .IDX_W     (IDX_W)
   ) u_imem (
      .clk   (clk),
      .we    (mem_we && reset),
      .widx  (load_idx),
      .wdata (load_data),
      .re    (fetch_go && reset),
      .ridx  (pc[IDX_W+1:2]),
      .rdata (rdata)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_q <= 1'b0;
         pc4_q <= '0;
         cnt_q <= '0;
      end else if (fetch_go) begin
         vld_q <= 1'b1;
         pc4_q <= pc + 32'd4;
         cnt_q <= cnt_q + 32'd1;
      end else if (bubble) begin
         vld_q <= 1'b0;
         pc4_q <= '0;
      end
   end

   // The RAM read register is unreset, so the valid flag masks it to NOP.
   assign instr       = vld_q ? rdata : NOP;
   assign pc_plus4    = pc4_q;
   assign if_valid    = vld_q;
   assign fault       = (state == FAULT);
   assign fetch_count = cnt_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed table-driven bench for instr_fetch plus a counter-wrap sequence.
module tb_instr_fetch;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic        stall;
   logic        flush;
   logic        load_en;
   logic [7:0]  load_idx;
   logic [31:0] load_data;
   logic [31:0] instr;
   logic [31:0] pc_plus4;
   logic        if_valid;
   logic        fault;
   logic [31:0] fetch_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   instr_fetch #(.MEM_WORDS(256), .IDX_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .pc          (pc),
      .stall       (stall),
      .flush       (flush),
      .load_en     (load_en),
      .load_idx    (load_idx),
      .load_data   (load_data),
      .instr       (instr),
      .pc_plus4    (pc_plus4),
      .if_valid    (if_valid),
      .fault       (fault),
      .fetch_count (fetch_count)
   );

   typedef struct {
      logic        rst_n;
      logic [31:0] pc;
      logic        stall;
      logic        flush;
      logic        ld;
      logic [7:0]  idx;
      logic [31:0] ldat;
      logic [31:0] e_instr;
      logic [31:0] e_pc4;
      logic        e_v;
      logic        e_f;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic [31:0] p, logic s, logic f, logic l,
                               logic [7:0] i, logic [31:0] d, logic [31:0] ei,
                               logic [31:0] ep, logic ev, logic ef, logic [31:0] ec);
      vec_t v;
      v.rst_n = r; v.pc = p; v.stall = s; v.flush = f; v.ld = l; v.idx = i; v.ldat = d;
      v.e_instr = ei; v.e_pc4 = ep; v.e_v = ev; v.e_f = ef; v.e_cnt = ec;
      return v;
   endfunction

   task automatic chk(input string name, input int step, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step %0d: got %h want %h", name, step, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      @(negedge clk);
      reset = v.rst_n; pc = v.pc; stall = v.stall; flush = v.flush;
      load_en = v.ld; load_idx = v.idx; load_data = v.ldat;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input vec_t v, input int step);
      chk("instr",       step, instr,              v.e_instr);
      chk("pc_plus4",    step, pc_plus4,           v.e_pc4);
      chk("if_valid",    step, {31'd0, if_valid},  {31'd0, v.e_v});
      chk("fault",       step, {31'd0, fault},     {31'd0, v.e_f});
      chk("fetch_count", step, fetch_count,        v.e_cnt);
   endtask

   initial begin
      reset = 1'b0; pc = '0; stall = 1'b0; flush = 1'b0;
      load_en = 1'b0; load_idx = '0; load_data = '0;

      //            rst pc            st fl ld idx    ldat           instr          pc4           v  f  cnt
      tbl.push_back(mk(0, 32'h0,       0, 0, 0, 8'd0, 32'h0,         32'h0,         32'h0,  0, 0, 0));
      tbl.push_back(mk(1, 32'h0,       0, 0, 1, 8'd0, 32'h2008_0005, 32'h0,         32'h0,  0, 0, 0));
      tbl.push_back(mk(1, 32'h0,       0, 0, 1, 8'd1, 32'h2009_0007, 32'h0,         32'h0,  0, 0, 0));
      tbl.push_back(mk(1, 32'h0,       0, 0, 1, 8'd2, 32'h0109_5020, 32'h0,         32'h0,  0, 0, 0));
      tbl.push_back(mk(1, 32'h0,       0, 0, 1, 8'd3, 32'hAC0A_0000, 32'h0,         32'h0,  0, 0, 0));
      tbl.push_back(mk(1, 32'h0,       0, 0, 0, 8'd0, 32'h0,         32'h2008_0005, 32'd4,  1, 0, 1));
      tbl.push_back(mk(1, 32'h4,       0, 0, 0, 8'd0, 32'h0,         32'h2009_0007, 32'd8,  1, 0, 2));
      tbl.push_back(mk(1, 32'h8,       0, 0, 0, 8'd0, 32'h0,         32'h0109_5020, 32'd12, 1, 0, 3));
      tbl.push_back(mk(1, 32'hC,       0, 0, 0, 8'd0, 32'h0,         32'hAC0A_0000, 32'd16, 1, 0, 4));
      tbl.push_back(mk(1, 32'h8,       0, 0, 0, 8'd0, 32'h0,         32'h0109_5020, 32'd12, 1, 0, 5));
      // two stall cycles, the second with a misaligned pc that must not fault
      tbl.push_back(mk(1, 32'hC,       1, 0, 0, 8'd0, 32'h0,         32'h0109_5020, 32'd12, 1, 0, 5));
      tbl.push_back(mk(1, 32'h6,       1, 0, 0, 8'd0, 32'h0,         32'h0109_5020, 32'd12, 1, 0, 5));
      tbl.push_back(mk(1, 32'h0,       1, 1, 0, 8'd0, 32'h0,         32'h0,         32'h0,  0, 0, 5));
      tbl.push_back(mk(1, 32'h400,     1, 0, 0, 8'd0, 32'h0,         32'h0,         32'h0,  0, 0, 5));
      tbl.push_back(mk(1, 32'h0,       0, 0, 1, 8'd5, 32'hDEAD_BEEF, 32'h0,         32'h0,  0, 0, 5));
      tbl.push_back(mk(1, 32'h14,      0, 0, 0, 8'd0, 32'h0,         32'hDEAD_BEEF, 32'h18, 1, 0, 6));
      tbl.push_back(mk(1, 32'h0,       0, 0, 1, 8'd6, 32'h6666_6666, 32'h0,         32'h0,  0, 0, 6));
      // flush outranks load: this write must be dropped
      tbl.push_back(mk(1, 32'h0,       0, 1, 1, 8'd6, 32'h1234_5678, 32'h0,         32'h0,  0, 0, 6));
      tbl.push_back(mk(1, 32'h18,      0, 0, 0, 8'd0, 32'h0,         32'h6666_6666, 32'h1C, 1, 0, 7));
      tbl.push_back(mk(1, 32'h6,       0, 0, 0, 8'd0, 32'h0,         32'h0,         32'h0,  0, 1, 7));
      tbl.push_back(mk(1, 32'h0,       0, 0, 0, 8'd0, 32'h0,         32'h0,         32'h0,  0, 1, 7));
      tbl.push_back(mk(1, 32'h0,       0, 0, 1, 8'd7, 32'h7777_7777, 32'h0,         32'h0,  0, 1, 7));
      tbl.push_back(mk(1, 32'h4,       1, 1, 0, 8'd0, 32'h0,         32'h0,         32'h0,  0, 1, 7));
      tbl.push_back(mk(0, 32'h0,       0, 0, 0, 8'd0, 32'h0,         32'h0,         32'h0,  0, 0, 0));
      tbl.push_back(mk(1, 32'h1C,      0, 0, 0, 8'd0, 32'h0,         32'h7777_7777, 32'h20, 1, 0, 1));
      tbl.push_back(mk(1, 32'h0,       0, 0, 0, 8'd0, 32'h0,         32'h2008_0005, 32'd4,  1, 0, 2));
      tbl.push_back(mk(1, 32'h400,     0, 0, 0, 8'd0, 32'h0,         32'h0,         32'h0,  0, 1, 2));
      tbl.push_back(mk(0, 32'h0,       0, 0, 0, 8'd0, 32'h0,         32'h0,         32'h0,  0, 0, 0));
      tbl.push_back(mk(1, 32'h4,       0, 0, 0, 8'd0, 32'h0,         32'h2009_0007, 32'd8,  1, 0, 1));
      // reset in the middle of a stall
      tbl.push_back(mk(1, 32'h8,       1, 0, 0, 8'd0, 32'h0,         32'h2009_0007, 32'd8,  1, 0, 1));
      tbl.push_back(mk(0, 32'h8,       1, 0, 0, 8'd0, 32'h0,         32'h0,         32'h0,  0, 0, 0));
      tbl.push_back(mk(1, 32'h8,       0, 0, 0, 8'd0, 32'h0,         32'h0109_5020, 32'd12, 1, 0, 1));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         check_all(tbl[i], i);
      end

      // counter wrap: preload all-ones, then one good fetch
      @(negedge clk);
      stall = 1'b1;
      force dut.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.cnt_q;
      chk("cnt_preload", 100, fetch_count, 32'hFFFF_FFFF);
      drive(mk(1, 32'hC, 0, 0, 0, 8'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0));
      chk("wrap_count", 101, fetch_count, 32'h0);
      chk("wrap_instr", 101, instr, 32'hAC0A_0000);
      chk("wrap_pc4",   101, pc_plus4, 32'd16);
      drive(mk(1, 32'h0, 1, 0, 0, 8'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0));
      chk("wrap_hold",  102, fetch_count, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch responder for the MIPS pipeline: consumes the fetch address driven by the PC each cycle, reads the word from an on-chip instruction memory, and registers the instruction and PC+4 into the IF/ID boundary. Supports pipeline stall and flush, in-place program loading, a sticky fault state for bad addresses, and a fetch counter for debug.

## Interface
Parameters:
- MEM_WORDS, 256: instruction memory depth in 32-bit words; power of two.
- IDX_W, 8: word-index width, log2(MEM_WORDS).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- pc  in  32  fetch byte address from PC.
- stall  in  1  hold IF/ID outputs.
- flush  in  1  replace IF/ID contents with a bubble.
- load_en  in  1  program-load write strobe.
- load_idx  in  IDX_W  word index for the load.
- load_data  in  32  word to write.
- instr  out  32  fetched instruction.
- pc_plus4  out  32  fetch address + 4.
- if_valid  out  1  instr/pc_plus4 hold a real fetch.
- fault  out  1  sticky bad-address flag.
- fetch_count  out  32  number of valid fetches since reset.

## Operation
- FSM states are RUN and FAULT. reset low forces RUN.
- RUN, one update per edge, priority reset > flush > load_en > stall > fetch:
  - flush: instr=NOP (32'h0000_0000), pc_plus4=0, if_valid=0.
  - load_en: mem[load_idx]=load_data. IF/ID outputs become a bubble (NOP, 0, 0), with no fetch that cycle.
  - stall: all outputs hold their values.
  - fetch, pc good: instr=mem[pc[IDX_W+1:2]], pc_plus4=pc+4 modulo 2^32, if_valid=1, fetch_count+1.
  - fetch, pc bad (pc[1:0]≠0 or pc[31:IDX_W+2]≠0): bubble, fault=1, next state FAULT.
- FAULT: IF/ID outputs are a bubble every cycle. stall, flush and fetch are ignored. load_en still writes memory. Exit only by reset.
- fetch_count wraps from 32'hFFFF_FFFF to 0. It holds on stall, flush, load, bubble and FAULT.
- Memory contents are not affected by reset; a program loaded before reset survives it.

## Timing
- Reset values: instr=0, pc_plus4=0, if_valid=0, fault=0, fetch_count=0, state=RUN.
- Fetch latency is 1 cycle. pc sampled at edge T appears on instr, pc_plus4 and if_valid immediately after edge T.
- Load latency: a word written at edge T can be fetched at edge T+1 or later.
- Stall asserted at edge T: outputs after T equal the outputs after T-1. The pc presented at T is dropped; the PC is responsible for holding it.
- Flush and stall asserted together: flush wins.
- Bad pc while stall=1 or flush=1 in RUN does not enter FAULT; the address is not fetched.
- reset low mid-stall or in FAULT: all outputs reach reset values after that edge.

## Structure
- Shared package mips_pkg holds:
  - NOP constant 32'h0000_0000
  - the fetch state enum {RUN, FAULT}
  - the XLEN=32 word-width constant
- Sub-module imem_ram: single-port memory, synchronous write, synchronous registered read, no reset. The read is disabled on load cycles. instr_fetch contains the FSM, the address check, the IF/ID registers and the counter.

## Test plan
- Reset, then load mem[0..3]=32'h2008_0005, 32'h2009_0007, 32'h0109_5020, 32'hAC0A_0000; release and drive pc=0,4,8,12 on successive edges -> instr follows the loaded words in order, pc_plus4=4,8,12,16, if_valid=1, fetch_count=4.
- Stall at pc=8 for 2 cycles -> instr=32'h0109_5020 and pc_plus4=12 held, fetch_count unchanged. Flush+stall together -> instr=0, if_valid=0.
- pc=32'h0000_0006 (misaligned) -> fault=1, if_valid=0. Later pc=0 -> outputs stay a bubble. Reset low -> fault=0, fetch_count=0.
- pc=32'h0000_0400 with default parameters (out of range) -> fault=1. Same pc with stall=1 -> no fault.
- load_en at idx 5 at edge T, then fetch pc=0x14 at T+1 -> new word returned. The load cycle itself shows if_valid=0.
- Preload fetch_count near wrap by forcing it to 32'hFFFF_FFFF in simulation, then one good fetch -> fetch_count=0.
